// File: rtl/pwm_capture.sv
// Multi-channel PWM decoder: measures period and high time of each input in clk cycles
// and serves the latest result per channel through a registered select/read port.
module pwm_capture #(
    parameter int NCH   = 8,
    parameter int CNT_W = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   pwm,
    input  logic             rd_en,
    input  logic [SEL_W-1:0] rd_sel,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_period,
    output logic [CNT_W-1:0] rd_high,
    output logic [NCH-1:0]   new_flags
);

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] period_all [NCH];
    logic [CNT_W-1:0] high_all   [NCH];
    logic [NCH-1:0]   rd_clr;

    logic [CNT_W-1:0] sel_period;
    logic [CNT_W-1:0] sel_high;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             prev;
        logic             rise;
        logic             sat;
        logic             capture;
        logic             stuck_entry;
        logic             flag;
        logic [CNT_W-1:0] period_cnt;
        logic [CNT_W-1:0] high_cnt;
        logic [CNT_W-1:0] period_reg;
        logic [CNT_W-1:0] high_reg;
        state_t           state;
        state_t           state_nxt;

        assign rise = s2 & ~prev;
        assign sat  = (period_cnt == CNT_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                prev <= 1'b0;
            end else begin
                s1   <= pwm[i];
                s2   <= s1;
                prev <= s2;
            end
        end

        // Both counters restart at 1 on a rise so a steady waveform reads back exactly P and H.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                period_cnt <= '0;
                high_cnt   <= '0;
            end else if (rise) begin
                period_cnt <= CNT_ONE;
                high_cnt   <= CNT_ONE;
            end else begin
                if (!sat) begin
                    period_cnt <= period_cnt + CNT_ONE;
                end
                if (s2 && (high_cnt != CNT_MAX)) begin
                    high_cnt <= high_cnt + CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ARM;
            end else begin
                state <= state_nxt;
            end
        end

        // A rise always takes priority over saturation on the same cycle.
        always_comb begin
            state_nxt   = state;
            capture     = 1'b0;
            stuck_entry = 1'b0;
            case (state)
                ARM: begin
                    if (rise) begin
                        state_nxt = MEAS;
                    end else if (sat) begin
                        state_nxt   = STUCK;
                        stuck_entry = 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        capture = 1'b1;
                    end else if (sat) begin
                        state_nxt   = STUCK;
                        stuck_entry = 1'b1;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state_nxt = MEAS;
                    end
                end
                default: begin
                    state_nxt = ARM;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                period_reg <= '0;
                high_reg   <= '0;
            end else if (capture) begin
                period_reg <= period_cnt;
                high_reg   <= high_cnt;
            end else if (stuck_entry) begin
                period_reg <= '0;
                high_reg   <= s2 ? CNT_MAX : '0;
            end
        end

        assign rd_clr[i] = rd_en && (rd_sel == SEL_W'(i));

        // A new result on the same cycle as a read leaves the flag set.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                flag <= 1'b0;
            end else if (capture || stuck_entry) begin
                flag <= 1'b1;
            end else if (rd_clr[i]) begin
                flag <= 1'b0;
            end
        end

        assign new_flags[i]  = flag;
        assign period_all[i] = period_reg;
        assign high_all[i]   = high_reg;
    end

    always_comb begin
        sel_period = '0;
        sel_high   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_period = period_all[i];
                sel_high   = high_all[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_period <= '0;
            rd_high   <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_period <= sel_period;
                rd_high   <= sel_high;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: a per-channel PWM generator drives the bus and
// every read-back is compared against hand-computed period/high values.
module tb_pwm_capture;

    localparam int NCH   = 8;
    localparam int CNT_W = 16;
    localparam int SEL_W = 3;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   pwm;
    logic             rd_en;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_period;
    logic [CNT_W-1:0] rd_high;
    logic [NCH-1:0]   new_flags;

    int compared;
    int mismatched;

    // Generator configuration: written only by the stimulus tasks.
    int  per_new     [NCH];
    int  hi_new      [NCH];
    bit  run         [NCH];
    bit  lvl         [NCH];
    int  restart_seq [NCH];

    // Generator state: written only by the generator process.
    int  per_cur     [NCH];
    int  hi_cur      [NCH];
    int  phase       [NCH];
    int  seen_seq    [NCH];

    pwm_capture #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm       (pwm),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_valid  (rd_valid),
        .rd_period (rd_period),
        .rd_high   (rd_high),
        .new_flags (new_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PWM changes on the falling edge, so each high phase spans exactly hi_cur rising edges.
    // New per/hi values take effect at the next period start; a restart begins a period at once.
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (run[i]) begin
                if (restart_seq[i] != seen_seq[i]) begin
                    seen_seq[i] = restart_seq[i];
                    phase[i]    = 0;
                    per_cur[i]  = per_new[i];
                    hi_cur[i]   = hi_new[i];
                end else if (phase[i] >= per_cur[i] - 1) begin
                    phase[i]   = 0;
                    per_cur[i] = per_new[i];
                    hi_cur[i]  = hi_new[i];
                end else begin
                    phase[i] = phase[i] + 1;
                end
                pwm[i] = (phase[i] < hi_cur[i]);
            end else begin
                pwm[i] = lvl[i];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared = compared + 1;
        if (observed !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the channel low briefly so the restart always produces a clean rising edge.
    task automatic applyStimulus(input int ch, input int p, input int h);
        run[ch] = 1'b0;
        lvl[ch] = 1'b0;
        waitCycles(4);
        per_new[ch]     = p;
        hi_new[ch]      = h;
        run[ch]         = 1'b1;
        restart_seq[ch] = restart_seq[ch] + 1;
    endtask

    task automatic holdChannel(input int ch, input bit v);
        run[ch] = 1'b0;
        lvl[ch] = v;
    endtask

    task automatic doRead(input int sel, output logic v, output logic [CNT_W-1:0] p,
                          output logic [CNT_W-1:0] h);
        @(posedge clk);
        #1;
        rd_en  = 1'b1;
        rd_sel = SEL_W'(sel);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        v = rd_valid;
        p = rd_period;
        h = rd_high;
    endtask

    // Returns just after the first rising clock edge that sees the channel high.
    task automatic waitPwmRise(input int ch, output bit ok);
        logic old;
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            old = pwm[ch];
            @(posedge clk);
            #1;
            if (!old && pwm[ch]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic             v;
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
        bit               ok;

        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < NCH; i++) begin
            per_new[i]     = 10;
            hi_new[i]      = 0;
            run[i]         = 1'b0;
            lvl[i]         = 1'b0;
            restart_seq[i] = 0;
        end
        rst_n  = 1'b0;
        rd_en  = 1'b0;
        rd_sel = '0;

        // Reset state
        waitCycles(3);
        checkOutput("rst_valid", rd_valid, 0);
        checkOutput("rst_period", rd_period, 0);
        checkOutput("rst_high", rd_high, 0);
        checkOutput("rst_flags", new_flags, 0);
        rst_n = 1'b1;

        // Ch0 256/64: first rise only arms, second rise yields the result
        applyStimulus(0, 256, 64);
        waitCycles(100);
        checkOutput("t1_flag_after_first_rise", new_flags[0], 0);
        waitCycles(200);
        checkOutput("t1_flag_after_second_rise", new_flags[0], 1);
        doRead(0, v, p, h);
        checkOutput("t1_valid", v, 1);
        checkOutput("t1_period", p, 256);
        checkOutput("t1_high", h, 64);
        checkOutput("t1_flag_cleared", new_flags[0], 0);
        waitCycles(1);
        checkOutput("t1_valid_pulse_ends", rd_valid, 0);

        // Reset in the middle of a period clears outputs immediately
        waitCycles(100);
        rst_n = 1'b0;
        #2;
        checkOutput("t5_period_in_reset", rd_period, 0);
        checkOutput("t5_high_in_reset", rd_high, 0);
        checkOutput("t5_flags_in_reset", new_flags, 0);
        waitCycles(3);
        rst_n = 1'b1;
        applyStimulus(0, 256, 64);
        waitCycles(100);
        checkOutput("t5_flag_after_first_rise", new_flags[0], 0);
        waitCycles(200);
        checkOutput("t5_flag_after_second_rise", new_flags[0], 1);
        doRead(0, v, p, h);
        checkOutput("t5_period", p, 256);
        checkOutput("t5_high", h, 64);

        // Ch2: read on the same cycle as a capture returns the old result, flag stays set
        applyStimulus(2, 50, 20);
        waitCycles(150);
        doRead(2, v, p, h);
        checkOutput("t4_initial_period", p, 50);
        checkOutput("t4_initial_high", h, 20);
        per_new[2] = 40;
        hi_new[2]  = 10;
        waitPwmRise(2, ok);
        checkOutput("t4_rise1_seen", ok, 1);
        waitPwmRise(2, ok);
        checkOutput("t4_rise2_seen", ok, 1);
        @(posedge clk);
        #1;
        rd_en  = 1'b1;
        rd_sel = 3'd2;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        checkOutput("t4_collide_valid", rd_valid, 1);
        checkOutput("t4_collide_period_old", rd_period, 50);
        checkOutput("t4_collide_high_old", rd_high, 20);
        checkOutput("t4_collide_flag_kept", new_flags[2], 1);
        doRead(2, v, p, h);
        checkOutput("t4_new_period", p, 40);
        checkOutput("t4_new_high", h, 10);
        checkOutput("t4_flag_cleared", new_flags[2], 0);

        // All channels at period 256, high 32*i; ch0 has no edges so keeps its last 256/64
        for (int i = 0; i < NCH; i++) begin
            applyStimulus(i, 256, 32 * i);
        end
        waitCycles(600);
        @(posedge clk);
        #1;
        rd_en  = 1'b1;
        rd_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            @(posedge clk);
            #1;
            if (i == NCH - 1) begin
                rd_en = 1'b0;
            end else begin
                rd_sel = SEL_W'(i + 1);
            end
            checkOutput($sformatf("t6_valid_ch%0d", i), rd_valid, 1);
            checkOutput($sformatf("t6_period_ch%0d", i), rd_period, 256);
            checkOutput($sformatf("t6_high_ch%0d", i), rd_high, (i == 0) ? 64 : 32 * i);
        end
        waitCycles(1);
        checkOutput("t6_valid_ends", rd_valid, 0);

        // Ch3 held high and ch0 held low until the period counters saturate
        holdChannel(3, 1'b1);
        waitCycles(10);
        doRead(3, v, p, h);
        checkOutput("t3_flag3_cleared", new_flags[3], 0);
        checkOutput("t2_flag0_clear_before", new_flags[0], 0);
        waitCycles(66000);
        checkOutput("t2_flag0_stuck", new_flags[0], 1);
        checkOutput("t3_flag3_stuck", new_flags[3], 1);
        doRead(0, v, p, h);
        checkOutput("t2_stuck_low_valid", v, 1);
        checkOutput("t2_stuck_low_period", p, 0);
        checkOutput("t2_stuck_low_high", h, 0);
        doRead(3, v, p, h);
        checkOutput("t3_stuck_high_period", p, 0);
        checkOutput("t3_stuck_high_high", h, 65535);
        waitCycles(1000);
        checkOutput("t3_flag3_set_once", new_flags[3], 0);
        checkOutput("t2_flag0_set_once", new_flags[0], 0);
        doRead(1, v, p, h);
        checkOutput("t2_ch1_still_period", p, 256);
        checkOutput("t2_ch1_still_high", h, 32);

        // Ch3 leaves STUCK on a rise, result only after the following rise
        applyStimulus(3, 100, 10);
        waitCycles(50);
        checkOutput("t3_restart_flag_first_rise", new_flags[3], 0);
        waitCycles(110);
        checkOutput("t3_restart_flag_second_rise", new_flags[3], 1);
        doRead(3, v, p, h);
        checkOutput("t3_restart_period", p, 100);
        checkOutput("t3_restart_high", h, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Multi-channel PWM decoder, the receive-side counterpart of pwm_generator. It samples an 8-bit bus of PWM waveforms and measures, per channel, the period and the high time in clk cycles. Results are held in per-channel registers and read out through a registered select/read port with sticky "new data" flags. Used in loopback self-test of pwm_generator and for monitoring externally driven PWM lines.

Parameters:
NCH, 8, number of PWM channels (bus width)
CNT_W, 16, width of period/high counters and results; timeout = 2^CNT_W-1 cycles
SEL_W, 3, width of channel select, must satisfy 2^SEL_W >= NCH

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pwm  input  NCH  PWM inputs, asynchronous to clk, bit i = channel i
rd_en  input  1  read strobe, one-cycle pulse
rd_sel  input  SEL_W  channel to read, sampled with rd_en
rd_valid  output  1  read data valid, one-cycle pulse
rd_period  output  CNT_W  period of selected channel in clk cycles (0 = stuck/no signal)
rd_high  output  CNT_W  high time of selected channel in clk cycles
new_flags  output  NCH  sticky per-channel "unread measurement" flags

Behaviour:
- Reset (async assert, sync release): all sync flops, counters and result registers = 0; every channel state = ARM; rd_valid=0, rd_period=0, rd_high=0, new_flags=0.
- Per channel: 2-flop synchronizer s1->s2, then prev<=s2. rise = s2 & ~prev. Rise is acted on at the 3rd clk edge after pwm[i] is first sampled high. Pulses shorter than 1 clk may be missed.
- Counters per channel: on rise, period_cnt<=1 and high_cnt<=1. Otherwise period_cnt+1, and high_cnt+1 while s2=1. Both saturate at 2^CNT_W-1.
- Per-channel state machine:
  - ARM: waiting for first rise. On rise -> MEAS (counters load, no result). On period_cnt saturation -> STUCK.
  - MEAS: on rise, period_reg<=period_cnt, high_reg<=high_cnt, new_flag<=1, stay MEAS. On period_cnt saturation -> STUCK.
  - STUCK: on entry, period_reg<=0, high_reg<=(s2 ? 2^CNT_W-1 : 0), new_flag<=1 (once, on entry only). On rise -> MEAS (arm only; first result after the following rise).
- Result semantics: for a steady waveform of period P and high time H (in clk cycles), the result is period=P, high=H. 0% and 100% duty produce no edges and so end in STUCK with high=0 or all-ones.
- Read port: on rd_en, the next cycle gives rd_valid=1 and rd_period/rd_high = the selected channel's registers as of the rd_en cycle. rd_valid is low otherwise; data holds its last value.
  - rd_en also clears new_flags[rd_sel].
  - If a capture on that channel coincides with rd_en, the returned data is the old value and the flag stays 1 (set wins).
  - rd_sel >= NCH returns 0/0 with rd_valid=1 and clears no flag.
  - Back-to-back rd_en every cycle is supported.
- Reset mid-measurement discards all state. The first valid result needs two rises after rst_n release.

Test Plan:
1. Reset, ch0 PWM with period 256 and high 64 (others 0) -> after 2nd rise, new_flags[0]=1. rd_en, rd_sel=0 -> next cycle rd_valid=1, rd_period=256, rd_high=64, new_flags[0]=0.
2. All 8 channels at period 256, highs 0,32,64,...,224 -> ch1..7 read period 256 with their highs. Ch0 after 65535 cycles reads period 0, high 0.
3. ch3 held high >65535 cycles after one rise -> STUCK: period 0, high 65535, flag set exactly once. Restart at period 100/high 10 -> 2nd rise after restart reads 100/10.
4. rd_en on ch2 in the same cycle as a ch2 capture -> returns previous values, new_flags[2] stays 1. Next read returns the new values and clears the flag.
5. Assert rst_n low mid-period, then release -> outputs 0 immediately. The first rise gives no flag; the second rise gives a correct result.
6. rd_en with rd_sel=0..7 on consecutive cycles -> 8 consecutive rd_valid pulses with matching data. rd_sel beyond NCH (only if NCH<2^SEL_W) -> returns 0/0.
